// File: rtl/fifo_rr_write_arbiter_pkg.sv
// Shared types and widths for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int GID_W  = 3;
  localparam int BCNT_W = 4;

endpackage

// File: rtl/fifo_rr_write_arbiter_if.sv
// Producer-side handshake plus FIFO write port shared by the arbiter and its environment.
interface fifo_rr_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_data;
  logic [GID_W-1:0]   grant_id;
  logic               busy;

  // Environment side: producers and the FIFO full flag.
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_data, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_rr_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [GID_W-1:0] rr_ptr,
  output logic             any,
  output logic [GID_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] win;

  // Doubling the vector turns the wrap-around scan into a plain window search.
  assign dbl = {req_valid, req_valid};

  generate
    for (genvar gi = 0; gi < 2 * NREQ; gi++) begin : g_win
      assign win[gi] = dbl[gi] && (gi >= int'(rr_ptr)) && (gi < int'(rr_ptr) + NREQ);
    end
  endgenerate

  always_comb begin
    any = |req_valid;
    idx = '0;
    for (int k = 2 * NREQ - 1; k >= 0; k--) begin
      if (win[k]) begin
        idx = GID_W'(k % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write arbiter: grants one producer at a time for up to BURST beats
// and drives the shared FIFO write port, stalling on fifo_full.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input logic                    clk,
  input logic                    rst,
  fifo_rr_write_arbiter_if.slave bus
);

  state_t             state_reg, state_next;
  logic [GID_W-1:0]   grant_id_reg, grant_id_next;
  logic [GID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [BCNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [BCNT_W-1:0]  beat_cnt_inc;

  logic               pick_any;
  logic [GID_W-1:0]   pick_idx;
  logic               gnt_valid;
  logic               gnt_last;
  logic [DW-1:0]      gnt_data;
  logic               granted;
  logic               beat;
  logic               release_grant;

  rr_priority_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_reg),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  // Select the current grantee's handshake and data from the registered grant_id.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_reg == GID_W'(i)) begin
        gnt_valid = bus.req_valid[i];
        gnt_last  = bus.req_last[i];
        gnt_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  // rst takes priority over a beat in flight, so neither side sees a handshake.
  assign granted = (state_reg == GRANT) && !rst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = granted && (grant_id_reg == GID_W'(gi)) && !bus.fifo_full;
    end
  endgenerate

  assign beat          = granted && gnt_valid && !bus.fifo_full;
  assign beat_cnt_inc  = beat_cnt_reg + BCNT_W'(1);
  assign release_grant = (state_reg == GRANT) &&
                         ((beat && (gnt_last || (beat_cnt_inc == BCNT_W'(BURST)))) ||
                          (!gnt_valid && !bus.fifo_full));

  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next    = GRANT;
          grant_id_next = pick_idx;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          beat_cnt_next = beat_cnt_inc;
        end
        if (release_grant) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_id_reg == GID_W'(NREQ - 1)) ? '0 : grant_id_reg + GID_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign bus.fifo_wr   = beat;
  assign bus.fifo_data = (state_reg == GRANT) ? gnt_data : '0;
  assign bus.grant_id  = grant_id_reg;
  assign bus.busy      = (state_reg == GRANT);

endmodule

// File: doc/fifo_rr_write_arbiter.md
# fifo_rr_write_arbiter

Round-robin write arbiter that shares one synchronous 8-deep × 8-bit FIFO among several producers. It sits directly in front of the FIFO's write port. It grants one producer at a time for a bounded burst and drives the FIFO's `wr` and `data_in`. It throttles producers against the FIFO `full` flag and guarantees fairness.

## Interface
Parameters:
- `NREQ`, 4 — number of producers (2..8)
- `DW`, 8 — data width; must match FIFO data width
- `BURST`, 4 — max beats per grant (1..15)

Ports:
- `clk` in 1 — clock
- `rst` in 1 — reset, synchronous, active-high
- `req_valid` in NREQ — producer i has a beat
- `req_data` in NREQ*DW — producer i data at bits [i*DW +: DW]
- `req_last` in NREQ — current beat ends producer i's burst
- `req_ready` out NREQ — one-hot or zero; beat accepted when valid&ready
- `fifo_full` in 1 — FIFO full flag
- `fifo_wr` out 1 — FIFO write strobe
- `fifo_data` out DW — FIFO write data
- `grant_id` out 3 — index of current grantee (valid when `busy`)
- `busy` out 1 — a grant is active

## Operation
- States: IDLE, GRANT.
- IDLE:
  - `req_ready`=0, `fifo_wr`=0.
  - If any `req_valid`: pick the first requester at or after `rr_ptr`, scanning upward and wrapping modulo NREQ. Register it into `grant_id`, clear `beat_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `req_ready[grant_id]` = !`fifo_full`. All other ready bits are 0.
  - beat = `req_valid[grant_id]` & `req_ready[grant_id]`.
  - `fifo_wr` = beat. `fifo_data` = `req_data[grant_id]`. Both are combinational from registered `grant_id`.
  - Each beat increments `beat_cnt` (4 bits).
- Release: go to IDLE and set `rr_ptr` = (`grant_id`+1) mod NREQ when any of the following holds:
  - a beat with `req_last[grant_id]`=1;
  - a beat that makes `beat_cnt`==BURST;
  - a GRANT cycle with `req_valid[grant_id]`=0 and `fifo_full`=0 (producer abandoned the burst).
- `fifo_full`=1 in GRANT: stall. No beat occurs, grant is held, `beat_cnt` holds, and there is no timeout. Deasserting valid while full does not release the grant.
- Requests from non-granted producers are ignored until the next IDLE cycle.
- `busy` = (state==GRANT).

## Timing
- Reset values:
  - state IDLE
  - `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0
  - `req_ready`=0, `fifo_wr`=0, `busy`=0
  - `fifo_data` is don't-care; drive 0 when not busy.
- Arbitration latency: valid seen in IDLE at edge n gives grant/ready at cycle n+1.
- First beat can be written at edge n+1 if `fifo_full`=0.
- Each release costs one IDLE cycle. Peak throughput is BURST beats per BURST+1 cycles.
- The FIFO samples `fifo_wr`/`fifo_data` at the same edge the producer sees its handshake. There is no extra buffering inside this block.
- `fifo_full` is used combinationally in the same cycle. The FIFO's full must be registered, so no combinational loop exists.
- `rst` mid-burst: next edge returns to IDLE and drops ready/wr. Any beat in that cycle is not written, because rst has priority.
- Round-robin wrap: after `grant_id`=NREQ-1, `rr_ptr`=0.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {IDLE, GRANT}
  - `GID_W`=3
  - `BCNT_W`=4
- Sub-module `rr_priority_picker`: combinational.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `any`, `idx`.
  - Implemented as a doubled-vector priority scan.
- Top holds the FSM, `beat_cnt`, `rr_ptr`, and the data mux.

## Test plan
- Single producer 0, 6 beats, `req_last` on beat 6, BURST=4, no full: beats 1–4 written, one IDLE cycle, grant 0 again, beats 5–6 written. `fifo_wr` pulses total 6. Data order preserved.
- All 4 producers continuously valid, each with `req_last` on every beat: grant sequence 0,1,2,3,0,1. Exactly one `req_ready` bit high per GRANT cycle. `fifo_wr` asserted every other cycle.
- Producer 2 granted, `fifo_full` asserted for 3 cycles after beat 1: ready=0 and wr=0 for 3 cycles, grant holds at 2, `beat_cnt` stays 1. Resumes on full deassert with beat 2 data.
- Producer 1 granted, drops valid after 2 beats with `fifo_full`=0: release next cycle, `rr_ptr`=2. Producer 3 waiting is granted next.
- `rst` asserted during beat 2 of a burst: next cycle busy=0, ready=0, wr=0. After release, the first grant goes to the lowest valid index (`rr_ptr`=0).
- Backpressure into real FIFO model: 3 producers × 5 beats with consumer idle. Exactly 8 beats accepted, then full stalls. Consumer drains, all 15 beats arrive, with no loss or duplication.
